// File: rtl/utf8_seq_pkg.sv
// Shared definitions for the UTF-8 encode sequencer: FSM state codes,
// code-point limits and the UTF-8 length rule.
package utf8_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_RST    = 3'd1;
    localparam state_t S_WR     = 3'd2;
    localparam state_t S_SETTLE = 3'd3;
    localparam state_t S_READ   = 3'd4;
    localparam state_t S_GAP    = 3'd5;
    localparam state_t S_DONE   = 3'd6;

    localparam logic [20:0] MAX_CP   = 21'h10FFFF;
    localparam logic [20:0] LEN2_MIN = 21'h000080;
    localparam logic [20:0] LEN3_MIN = 21'h000800;
    localparam logic [20:0] LEN4_MIN = 21'h010000;

    function automatic logic [2:0] utf8_len(input logic [20:0] cp);
        if (cp < LEN2_MIN)      return 3'd1;
        else if (cp < LEN3_MIN) return 3'd2;
        else if (cp < LEN4_MIN) return 3'd3;
        else                    return 3'd4;
    endfunction

endpackage

// File: rtl/utf8_seq_strobe_gen.sv
// One-cycle active-low strobe with a forced high cycle after every strobe.
// Reset suppresses the strobe on the edge where it is sampled.
module utf8_seq_strobe_gen (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    output logic strobe_n_o
);

    logic fired_q;
    logic fire;

    assign fire       = req_i & ~fired_q & ~rst;
    assign strobe_n_o = ~fire;

    always_ff @(posedge clk) begin
        if (rst) fired_q <= 1'b0;
        else     fired_q <= fire;
    end

endmodule

// File: rtl/utf8_encode_sequencer.sv
// Drives the transcoder core through one code-point-to-UTF-8 encode per request.
// Optional build macro: UTF8_SEQ_RANGE_CHK_EN (core range check + pre-reject of cp > MAX_CP).
module utf8_encode_sequencer
    import utf8_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int TIMEOUT       = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cp_valid,
    output logic        cp_ready,
    input  logic [20:0] cp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        done,
    output logic        err_invalid,
    output logic        err_timeout,
    output logic [7:0]  core_din,
    input  logic [7:0]  core_dout,
    output logic        core_cbe,
    output logic        core_cin_n,
    output logic        core_bout_n,
    input  logic        core_bout_eof,
    input  logic        core_error,
    output logic        core_rst_in_n,
    output logic        core_rst_out_n,
    output logic        core_chk_range
);

    state_t      state_q, state_d;
    logic [20:0] cp_q, cp_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  settle_q, settle_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  tmo_q, tmo_d;
    logic        err_inv_q, err_inv_d;
    logic        err_tmo_q, err_tmo_d;
    logic        xfer;
    logic [7:0]  wr_byte;

    assign cp_ready       = (state_q == S_IDLE);
    assign done           = (state_q == S_DONE);
    assign err_invalid    = err_inv_q;
    assign err_timeout    = err_tmo_q;
    assign out_valid      = (state_q == S_READ) & ~core_bout_eof;
    assign out_data       = core_dout;
    assign out_last       = (state_q == S_READ) & ((cnt_q + 3'd1) == len_q);
    assign xfer           = out_valid & out_ready;
    assign core_cbe       = 1'b1;
    assign core_rst_in_n  = (state_q != S_RST);
    assign core_rst_out_n = (state_q != S_RST);
`ifdef UTF8_SEQ_RANGE_CHK_EN
    assign core_chk_range = 1'b1;
`else
    assign core_chk_range = 1'b0;
`endif

    // Code point goes to the core as a 32-bit big-endian word.
    always_comb begin
        case (idx_q[2:1])
            2'd0:    wr_byte = 8'h00;
            2'd1:    wr_byte = {3'b000, cp_q[20:16]};
            2'd2:    wr_byte = cp_q[15:8];
            default: wr_byte = cp_q[7:0];
        endcase
    end
    assign core_din = (state_q == S_WR) ? wr_byte : 8'h00;

    utf8_seq_strobe_gen u_cin (
        .clk        (clk),
        .rst        (rst),
        .req_i      ((state_q == S_WR) & ~idx_q[0]),
        .strobe_n_o (core_cin_n)
    );

    utf8_seq_strobe_gen u_bout (
        .clk        (clk),
        .rst        (rst),
        .req_i      (xfer),
        .strobe_n_o (core_bout_n)
    );

    always_comb begin
        state_d   = state_q;
        cp_d      = cp_q;
        len_d     = len_q;
        idx_d     = idx_q;
        settle_d  = settle_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        err_inv_d = err_inv_q;
        err_tmo_d = err_tmo_q;
        case (state_q)
            S_IDLE: begin
                tmo_d = 4'd0;
                if (cp_valid) begin
                    cp_d      = cp_data;
                    len_d     = utf8_len(cp_data);
                    err_inv_d = 1'b0;
                    err_tmo_d = 1'b0;
                    idx_d     = 3'd0;
                    settle_d  = 3'd0;
                    cnt_d     = 3'd0;
`ifdef UTF8_SEQ_RANGE_CHK_EN
                    if (cp_data > MAX_CP) begin
                        err_inv_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_RST;
                    end
`else
                    state_d   = S_RST;
`endif
                end
            end
            S_RST: begin
                idx_d   = 3'd0;
                state_d = S_WR;
            end
            S_WR: begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    settle_d = 3'd0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == 3'(SETTLE_CYCLES - 1)) begin
                    if (core_error) begin
                        err_inv_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        cnt_d   = 3'd0;
                        tmo_d   = 4'd0;
                        state_d = S_READ;
                    end
                end else begin
                    settle_d = settle_q + 3'd1;
                end
            end
            S_READ: begin
                if (xfer) begin
                    cnt_d   = cnt_q + 3'd1;
                    tmo_d   = 4'd0;
                    state_d = out_last ? S_DONE : S_GAP;
                end else if (core_bout_eof) begin
                    // Core ran dry before the expected length.
                    err_tmo_d = 1'b1;
                    state_d   = S_DONE;
                end else if (tmo_q == 4'(TIMEOUT - 1)) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end
            S_GAP:   state_d = S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            settle_q  <= 3'd0;
            cnt_q     <= 3'd0;
            tmo_q     <= 4'd0;
            err_inv_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            settle_q  <= settle_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            err_inv_q <= err_inv_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        cp_q  <= cp_d;
        len_q <= len_d;
    end

endmodule
